// File: rtl/fixed_point_sub_arbiter.sv
// Two-requester round-robin front end sharing one sign-magnitude subtractor.
// Each accepted operation passes IDLE -> CALC -> DONE and holds its result until the consumer takes it.
module fixed_point_sub_arbiter #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_c,
    output logic         out_id,
    output logic         out_ovf,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Ready never depends on the consumer; out_valid never depends on the requesters.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q;
    logic           grant;
    logic           accept;
    logic [N-1:0]   a_q, b_q;
    logic           id_q;

    logic           sa, sb;
    logic [N-2:0]   ma, mb, mag;
    logic [N-1:0]   sum;
    logic           sgn, ovf;

    // Q only documents the binary point; the subtractor is format-agnostic.
    if (Q >= N) begin : g_q_wider_than_word
    end

    assign grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign accept    = req0_ready | req1_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = rst_n & req0_valid & ~grant;
                req1_ready = rst_n & req1_valid & grant;
                if (req0_ready || req1_ready) state_d = CALC;
            end
            CALC:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sa  = a_q[N-1];
        sb  = b_q[N-1];
        ma  = a_q[N-2:0];
        mb  = b_q[N-2:0];
        sum = {1'b0, ma} + {1'b0, mb};
        mag = '0;
        sgn = 1'b0;
        ovf = 1'b0;
        if (sa != sb) begin
            mag = sum[N-2:0];
            sgn = sa;
            ovf = sum[N-1];
        end else if (ma >= mb) begin
            mag = ma - mb;
            sgn = sa;
        end else begin
            mag = mb - ma;
            sgn = ~sa;
        end
        // A zero magnitude is always reported as +0.
        if (mag == '0) sgn = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            out_c        <= '0;
            out_id       <= 1'b0;
            out_ovf      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q          <= grant ? req1_a : req0_a;
                b_q          <= grant ? req1_b : req0_b;
                id_q         <= grant;
                last_grant_q <= grant;
            end
            if (state_q == CALC) begin
                out_c   <= {sgn, mag};
                out_ovf <= ovf;
                out_id  <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_sub_arbiter.sv
// Directed bench for fixed_point_sub_arbiter: arithmetic vectors, timing, arbitration,
// backpressure and reset behaviour, with an in-order result scoreboard.
module tb_fixed_point_sub_arbiter;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_c;
    logic         out_id, out_ovf, busy;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N+1:0] exp_q[$];
    logic [N+1:0] exp_item;

    fixed_point_sub_arbiter #(.Q(15), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_id(out_id),
        .out_ovf(out_ovf), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every completed transfer must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                exp_item = exp_q.pop_front();
                check("sb_result", {out_id, out_ovf, out_c}, exp_item);
            end
        end
    end

    // driver: one operation on requester id, optionally holding out_ready low in DONE
    task automatic issue(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_c, input logic exp_ovf, input int hold);
        int   waited;
        logic rdy;
        @(posedge clk); #1;
        out_ready = (hold == 0);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        waited = 0;
        do begin
            @(negedge clk);
            rdy = id ? req1_ready : req0_ready;
            waited++;
        end while (!rdy && waited < 20);
        check("accept_ready", rdy, 1);
        if (!rdy) begin
            req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
            return;
        end
        exp_q.push_back({id, exp_ovf, exp_c});
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        @(negedge clk);
        check("calc_out_valid", out_valid, 0);
        check("calc_busy", busy, 1);
        check("calc_state", dbg_state, 2'd1);
        check("calc_readys", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        check("done_out_valid", out_valid, 1);
        if (hold > 0) begin
            if (id) req0_valid = 1'b1; else req1_valid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                check("bp_out_valid", out_valid, 1);
                check("bp_out_c", out_c, exp_c);
                check("bp_out_id", out_id, id);
                check("bp_out_ovf", out_ovf, exp_ovf);
                check("bp_busy", busy, 1);
                check("bp_readys", {req0_ready, req1_ready}, 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    logic [N-1:0] va[11], vb[11], vc[11];
    logic         vo[11];
    int n_acc, c0, c1, cyc;

    initial begin
        va = '{32'h0001_8000, 32'h0000_8000, 32'h0000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 32'h8001_0000,
               32'h8001_8000, 32'h8000_8000, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0000};
        vb = '{32'h0000_8000, 32'h0001_8000, 32'h8000_8000, 32'h8000_8000, 32'h8000_0001, 32'h0000_8000,
               32'h8000_8000, 32'h8001_8000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
        vc = '{32'h0001_0000, 32'h8001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h8001_8000,
               32'h8001_0000, 32'h0001_0000, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000};
        vo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // reset state, with both requesters asserting valid
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_c", out_c, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_ovf", out_ovf, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        apply_reset();

        // arithmetic vectors, alternating requesters
        for (int i = 0; i < 11; i++) issue(i[0], va[i], vb[i], vc[i], vo[i], 0);

        // backpressure
        issue(1'b1, 32'h0003_0000, 32'h0001_0000, 32'h0002_0000, 1'b0, 5);

        // contention straight after reset
        apply_reset();
        @(posedge clk); #1;
        req0_a = 32'h0003_0000; req0_b = 32'h0001_0000;
        req1_a = 32'h0001_0000; req1_b = 32'h0003_0000;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, 1'b0, 32'h0002_0000});
            exp_q.push_back({1'b1, 1'b0, 32'h8002_0000});
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        n_acc = 0; c0 = 0; c1 = 0; cyc = 0;
        while (n_acc < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req0_ready) c0++;
            if (req1_ready) c1++;
            if (req0_ready || req1_ready) n_acc++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_accepts", n_acc, 4);
        check("rr_req0_ready_cycles", c0, 2);
        check("rr_req1_ready_cycles", c1, 2);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rr_drain", exp_q.size(), 0);

        // reset during CALC
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 32'h0005_0000; req1_b = 32'h0001_0000;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!req1_ready && cyc < 20);
        check("mid_accept_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        check("mid_state_calc", dbg_state, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_c", out_c, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_out_valid", out_valid, 0);
        end

        check("sb_final_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
